// File: rtl/lddw_sequencer.sv
// Fetch-to-execute sequencer: forwards ordinary slots through a one-entry buffer and turns
// lddw slot pairs into a single 64-bit register-file write. Optional: LDDW_SLOT2_CHECK_EN.
module lddw_sequencer #(
  parameter logic [7:0]  LDDW_OPCODE = 8'h18,
  parameter int unsigned NUM_REGS    = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_i,
  input  logic [63:0] instr_i,
  output logic        instr_ready_o,
  input  logic        flush_i,
  output logic        exec_valid_o,
  output logic [63:0] exec_instr_o,
  input  logic        exec_ready_i,
  output logic        rf_wr_en_o,
  output logic [3:0]  rf_wr_addr_o,
  output logic [63:0] rf_wr_data_o,
  output logic        busy_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {StIdle, StWaitHi, StWrite} state_e;

  state_e      state_q, state_d;
  logic        exec_valid_q, exec_valid_d;
  logic [63:0] exec_instr_q, exec_instr_d;
  logic [3:0]  dst_q, dst_d;
  logic [31:0] imm_lo_q, imm_lo_d;
  logic        rf_wr_en_q, rf_wr_en_d;
  logic [3:0]  rf_wr_addr_q, rf_wr_addr_d;
  logic [63:0] rf_wr_data_q, rf_wr_data_d;
  logic        illegal_q, illegal_d;

  logic buf_free, accept, is_lddw, dst_legal, slot2_ok;

  assign buf_free  = !exec_valid_q || exec_ready_i;
  assign is_lddw   = (instr_i[7:0] == LDDW_OPCODE);
  assign dst_legal = (32'(dst_q) < NUM_REGS);

`ifdef LDDW_SLOT2_CHECK_EN
  assign slot2_ok = (instr_i[31:0] == 32'h0);
`else
  assign slot2_ok = 1'b1;
`endif

  always_comb begin
    instr_ready_o = 1'b0;
    if (!flush_i) begin
      unique case (state_q)
        StIdle:   instr_ready_o = buf_free;
        StWaitHi: instr_ready_o = 1'b1;
        default:  instr_ready_o = 1'b0;
      endcase
    end
  end

  assign accept = instr_valid_i && instr_ready_o;

  always_comb begin
    state_d      = state_q;
    exec_valid_d = exec_valid_q;
    exec_instr_d = exec_instr_q;
    dst_d        = dst_q;
    imm_lo_d     = imm_lo_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    illegal_d    = 1'b0;

    if (exec_valid_q && exec_ready_i) exec_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_lddw) begin
            dst_d    = instr_i[11:8];
            imm_lo_d = instr_i[63:32];
            state_d  = StWaitHi;
          end else begin
            exec_valid_d = 1'b1;
            exec_instr_d = instr_i;
          end
        end
      end
      StWaitHi: begin
        // Slot 2 is always swallowed; the write strobe is registered so it lands in StWrite.
        if (accept) begin
          rf_wr_en_d   = dst_legal && slot2_ok;
          illegal_d    = !(dst_legal && slot2_ok);
          rf_wr_addr_d = dst_q;
          rf_wr_data_d = {instr_i[63:32], imm_lo_q};
          state_d      = StWrite;
        end
      end
      default: state_d = StIdle;
    endcase

    // A write already in StWrite completes; an open pair is abandoned.
    if (flush_i) begin
      exec_valid_d = 1'b0;
      state_d      = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      exec_valid_q <= 1'b0;
      exec_instr_q <= 64'h0;
      dst_q        <= 4'h0;
      imm_lo_q     <= 32'h0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= 4'h0;
      rf_wr_data_q <= 64'h0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      exec_valid_q <= exec_valid_d;
      exec_instr_q <= exec_instr_d;
      dst_q        <= dst_d;
      imm_lo_q     <= imm_lo_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      illegal_q    <= illegal_d;
    end
  end

  assign exec_valid_o = exec_valid_q;
  assign exec_instr_o = exec_instr_q;
  assign rf_wr_en_o   = rf_wr_en_q;
  assign rf_wr_addr_o = rf_wr_addr_q;
  assign rf_wr_data_o = rf_wr_data_q;
  assign illegal_o    = illegal_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_lddw_sequencer.sv
// Directed bench for lddw_sequencer: forwarding, lddw pairs, back-pressure, flush, illegal dst,
// back-to-back pairs and mid-pair reset.
module tb_lddw_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [63:0] instr;
  logic        instr_ready;
  logic        flush;
  logic        exec_valid;
  logic [63:0] exec_instr;
  logic        exec_ready;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [63:0] rf_wr_data;
  logic        busy;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  lddw_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid),
    .instr_i       (instr),
    .instr_ready_o (instr_ready),
    .flush_i       (flush),
    .exec_valid_o  (exec_valid),
    .exec_instr_o  (exec_instr),
    .exec_ready_i  (exec_ready),
    .rf_wr_en_o    (rf_wr_en),
    .rf_wr_addr_o  (rf_wr_addr),
    .rf_wr_data_o  (rf_wr_data),
    .busy_o        (busy),
    .illegal_o     (illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 64'h0; flush = 1'b0; exec_ready = 1'b1;
    #12;
    check("rst_exec_valid", {63'h0, exec_valid}, 64'h0);
    check("rst_exec_instr", exec_instr, 64'h0);
    check("rst_rf_wr_en",   {63'h0, rf_wr_en}, 64'h0);
    check("rst_rf_wr_data", rf_wr_data, 64'h0);
    check("rst_busy",       {63'h0, busy}, 64'h0);
    check("rst_illegal",    {63'h0, illegal}, 64'h0);
    step();
    rst_n = 1'b1;
    step();

    // mov r1,5 forwarded with latency 1
    instr_valid = 1'b1; instr = 64'h0000_0005_0000_01B7;
    #1 check("mov_ready", {63'h0, instr_ready}, 64'h1);
    step();
    instr_valid = 1'b0;
    check("mov_exec_valid", {63'h0, exec_valid}, 64'h1);
    check("mov_exec_instr", exec_instr, 64'h0000_0005_0000_01B7);
    check("mov_no_wr",      {63'h0, rf_wr_en}, 64'h0);
    step();
    check("mov_drained", {63'h0, exec_valid}, 64'h0);

    // lddw r3 pair
    instr_valid = 1'b1; instr = 64'h1234_5678_0000_0318;
    step();
    check("p1_busy_hi", {63'h0, busy}, 64'h1);
    check("p1_no_exec", {63'h0, exec_valid}, 64'h0);
    instr = 64'h9ABC_DEF0_0000_0000;
    step();
    instr_valid = 1'b0;
    check("p1_wr_en",   {63'h0, rf_wr_en}, 64'h1);
    check("p1_wr_addr", {60'h0, rf_wr_addr}, 64'h3);
    check("p1_wr_data", rf_wr_data, 64'h9ABC_DEF0_1234_5678);
    check("p1_illegal", {63'h0, illegal}, 64'h0);
    check("p1_ready_wr", {63'h0, instr_ready}, 64'h0);
    check("p1_no_exec2", {63'h0, exec_valid}, 64'h0);
    step();
    check("p1_wr_done", {63'h0, rf_wr_en}, 64'h0);
    check("p1_idle",    {63'h0, busy}, 64'h0);

    // back-pressure: buffer full blocks lddw slot 1
    exec_ready = 1'b0; instr_valid = 1'b1; instr = 64'h0000_0009_0000_04B7;
    step();
    instr = 64'hAAAA_BBBB_0000_0518;
    #1 check("bp_blocked", {63'h0, instr_ready}, 64'h0);
    step();
    check("bp_not_busy",  {63'h0, busy}, 64'h0);
    check("bp_held",      exec_instr, 64'h0000_0009_0000_04B7);
    exec_ready = 1'b1;
    #1 check("bp_ready", {63'h0, instr_ready}, 64'h1);
    step();
    check("bp_drained", {63'h0, exec_valid}, 64'h0);
    check("bp_busy",    {63'h0, busy}, 64'h1);
    instr = 64'h1111_2222_0000_0000;
    step();
    instr_valid = 1'b0;
    check("bp_wr_en",   {63'h0, rf_wr_en}, 64'h1);
    check("bp_wr_addr", {60'h0, rf_wr_addr}, 64'h5);
    check("bp_wr_data", rf_wr_data, 64'h1111_2222_AAAA_BBBB);
    step();

    // flush abandons an open pair
    instr_valid = 1'b1; instr = 64'h5555_5555_0000_0618;
    step();
    instr = 64'h6666_6666_0000_0000; flush = 1'b1;
    #1 check("fl_ready_low", {63'h0, instr_ready}, 64'h0);
    step();
    flush = 1'b0; instr_valid = 1'b0;
    check("fl_idle",  {63'h0, busy}, 64'h0);
    check("fl_no_wr", {63'h0, rf_wr_en}, 64'h0);
    step();
    check("fl_no_wr2", {63'h0, rf_wr_en}, 64'h0);
    instr_valid = 1'b1; instr = 64'h0000_0007_0000_02B7;
    step();
    instr_valid = 1'b0;
    check("fl_mov_valid", {63'h0, exec_valid}, 64'h1);
    check("fl_mov_instr", exec_instr, 64'h0000_0007_0000_02B7);
    step();

    // illegal dst 12
    instr_valid = 1'b1; instr = 64'h0000_0001_0000_0C18;
    step();
    instr = 64'h0000_0002_0000_0000;
    step();
    instr_valid = 1'b0;
    check("il_pulse", {63'h0, illegal}, 64'h1);
    check("il_no_wr", {63'h0, rf_wr_en}, 64'h0);
    check("il_busy",  {63'h0, busy}, 64'h1);
    step();
    check("il_pulse_end", {63'h0, illegal}, 64'h0);
    check("il_idle",      {63'h0, busy}, 64'h0);

    // non-zero low word in slot 2
    instr_valid = 1'b1; instr = 64'h0000_0003_0000_0218;
    step();
    instr = 64'h0000_0001_0000_0018;
    step();
    instr_valid = 1'b0;
`ifdef LDDW_SLOT2_CHECK_EN
    check("s2_illegal", {63'h0, illegal}, 64'h1);
    check("s2_no_wr",   {63'h0, rf_wr_en}, 64'h0);
`else
    check("s2_legal",   {63'h0, illegal}, 64'h0);
    check("s2_wr_en",   {63'h0, rf_wr_en}, 64'h1);
    check("s2_wr_data", rf_wr_data, 64'h0000_0001_0000_0003);
`endif
    step();

    // back-to-back pairs, writes 3 cycles apart
    instr_valid = 1'b1; instr = 64'h0000_00A1_0000_0118;
    step();
    instr = 64'h0000_00B1_0000_0000;
    step();
    instr = 64'h0000_00A2_0000_0218;
    check("bb1_wr_en",   {63'h0, rf_wr_en}, 64'h1);
    check("bb1_wr_addr", {60'h0, rf_wr_addr}, 64'h1);
    check("bb1_wr_data", rf_wr_data, 64'h0000_00B1_0000_00A1);
    check("bb1_ready",   {63'h0, instr_ready}, 64'h0);
    step();
    check("bb_gap_wr",    {63'h0, rf_wr_en}, 64'h0);
    check("bb_gap_ready", {63'h0, instr_ready}, 64'h1);
    step();
    instr = 64'h0000_00B2_0000_0000;
    check("bb_hi_ready", {63'h0, instr_ready}, 64'h1);
    check("bb_hi_no_wr", {63'h0, rf_wr_en}, 64'h0);
    step();
    instr_valid = 1'b0;
    check("bb2_wr_en",   {63'h0, rf_wr_en}, 64'h1);
    check("bb2_wr_addr", {60'h0, rf_wr_addr}, 64'h2);
    check("bb2_wr_data", rf_wr_data, 64'h0000_00B2_0000_00A2);
    check("bb2_ready",   {63'h0, instr_ready}, 64'h0);
    step();
    check("bb2_done", {63'h0, rf_wr_en}, 64'h0);

    // reset mid-pair
    instr_valid = 1'b1; instr = 64'h7777_7777_0000_0718;
    step();
    instr_valid = 1'b0;
    check("mr_busy", {63'h0, busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("mr_busy_clr", {63'h0, busy}, 64'h0);
    check("mr_data_clr", rf_wr_data, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    check("mr_no_wr", {63'h0, rf_wr_en}, 64'h0);
    check("mr_idle",  {63'h0, busy}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lddw_sequencer.md
Name: lddw_sequencer

Overview:
- Sits between instruction fetch and execute in the eBPF soft CPU.
- Forwards ordinary instructions to execute through a one-entry registered stage.
- Absorbs the two-slot lddw (load 64-bit immediate) pair: latches dst and the low imm from slot 1, takes the high imm from slot 2, then issues one 64-bit register-file write.
- Owns the dst-hold function for lddw and sequences the fetch, execute and register-file interfaces.

Parameters:
- LDDW_OPCODE, 8'h18, opcode that identifies slot 1 of an lddw pair.
- NUM_REGS, 11, number of architectural registers; a dst >= NUM_REGS is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  fetch has an instruction slot on instr.
- instr  input  64  eBPF slot: [7:0] opcode, [11:8] dst, [15:12] src, [31:16] off, [63:32] imm.
- instr_ready  output  1  slot accepted when instr_valid && instr_ready.
- flush  input  1  branch/trap flush; discards in-flight work.
- exec_valid  output  1  exec_instr holds a valid non-lddw instruction.
- exec_instr  output  64  registered instruction to execute.
- exec_ready  input  1  execute consumes exec_instr when exec_valid && exec_ready.
- rf_wr_en  output  1  one-cycle register-file write strobe (the register file always accepts).
- rf_wr_addr  output  4  write register index.
- rf_wr_data  output  64  {imm_hi, imm_lo}.
- busy  output  1  high in WAIT_HI or WRITE.
- illegal  output  1  one-cycle pulse on a malformed lddw.

Behaviour:
- Reset values (async on rst_n low): state=IDLE, exec_valid=0, exec_instr=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, illegal=0, internal latches=0.
- Output stage: exec_valid/exec_instr form a registered one-entry buffer. The buffer is free when !exec_valid || exec_ready.
- FSM states: IDLE, WAIT_HI, WRITE.
- IDLE:
  - instr_ready = buffer free.
  - Accepted non-lddw slot: loads the buffer, visible on exec_valid the next cycle (latency 1).
  - Accepted slot with opcode==LDDW_OPCODE: latches dst and imm_lo, goes to WAIT_HI, and does not load the buffer.
- WAIT_HI:
  - instr_ready = 1.
  - Accepted slot: latches instr[63:32] as imm_hi and goes to WRITE. The slot is never forwarded, whatever its opcode.
- WRITE:
  - rf_wr_en = 1 for exactly one cycle, with rf_wr_addr = latched dst and rf_wr_data = {imm_hi, imm_lo}.
  - instr_ready = 0.
  - Next state is IDLE.
  - Latency is 1 cycle from slot-2 acceptance to rf_wr_en.
- Ordering: a non-lddw instruction still held in the buffer is not reordered against the lddw write. Leaving IDLE for an lddw is allowed only when the buffer is free, so older instructions have already drained or are draining.
- Illegal dst: an lddw slot 1 with dst >= NUM_REGS is accepted. It pulses illegal the same cycle the pair completes, and the rf write is suppressed (rf_wr_en stays 0) while the FSM still passes through WRITE.
- busy = (state != IDLE).
- flush:
  - Synchronous, with highest priority.
  - Clears exec_valid.
  - Returns WAIT_HI to IDLE without a write.
  - A slot presented the same cycle as flush is not accepted (instr_ready=0 while flush is high).
  - flush in WRITE: the write completes and the FSM returns to IDLE.
- Back-to-back lddw pairs are legal. Minimum spacing is 3 cycles per pair (slot1, slot2, WRITE).
- Reset asserted mid-pair: all state is lost, no write is issued, and the outputs return to their reset values immediately.

Optional Feature:
- Macro: LDDW_SLOT2_CHECK_EN.
- When defined: slot 2 must have bits [31:0] == 0 (eBPF pseudo-instruction rule). If not, illegal pulses during WRITE and the rf write is suppressed.
- When undefined: slot-2 bits [31:0] are ignored, and illegal is driven only by the dst range check.

Test Plan:
- Reset, then instr=64'h0000_0005_0000_01B7 (mov r1,5) with exec_ready=1: exec_valid=1 next cycle, exec_instr equal to input, rf_wr_en never asserted.
- Slot1 64'h1234_5678_0000_0318, then slot2 64'h9ABC_DEF0_0000_0000 on consecutive cycles: one cycle after slot 2, rf_wr_en=1, rf_wr_addr=3, rf_wr_data=64'h9ABC_DEF0_1234_5678; exec_valid stays 0 throughout.
- exec_ready held 0 with the buffer full, then an lddw slot 1 presented: instr_ready=0 until exec_ready=1 drains the buffer; the pair then completes with a correct write.
- lddw slot 1 accepted, flush=1 next cycle: state returns to IDLE, busy=0, no rf_wr_en; the next mov is forwarded normally.
- lddw slot 1 with dst=4'hC: illegal pulses once, rf_wr_en stays 0. With LDDW_SLOT2_CHECK_EN defined, a slot 2 of 64'h0000_0001_0000_0018 on dst=2 also pulses illegal with no write.
- Two back-to-back lddw pairs (dst 1, then dst 2): two rf writes 3 cycles apart carrying the correct data, and instr_ready=0 only in the WRITE cycles.
